// File: rtl/con_mem_loader_if.sv
// Byte-stream in / BLOCKMEM con_* write port and load status between the loader and its environment.
// master: the loader side; slave: the byte source and memory side.
interface con_mem_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [3:0]        con_write;
  logic [ADDR_W-1:0] con_addr;
  logic [31:0]       con_in;
  logic              core_nrst;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx_data, rx_valid,
    output con_write, con_addr, con_in, core_nrst, load_busy, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  con_write, con_addr, con_in, core_nrst, load_busy, load_done, load_err
  );
endinterface

// File: rtl/con_mem_loader.sv
// Assembles framed UART bytes into 32-bit words and writes them to BLOCKMEM, holding the core in reset.
// Define CON_LOADER_CHKSUM_EN to expect a trailing XOR checksum byte per frame.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, other bytes dropped
// ADDR0 | expecting start word address, low byte
// ADDR1 | expecting start word address, high byte
// LEN0  | expecting word count, low byte
// LEN1  | expecting word count, high byte
// DATA  | assembling data bytes into words, writing each completed word
// CHK   | expecting XOR checksum of all data bytes (checksum build only)
module con_mem_loader #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             nrst,
  con_mem_loader_if.master bus
);
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CHK} state_t;

  state_t            state;
  logic [7:0]        addr_lo;
  logic [7:0]        len_lo;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sr;
  logic [TMR_W-1:0]  tmr;
  logic              done_pend;
`ifdef CON_LOADER_CHKSUM_EN
  logic [7:0]        chk_acc;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (!nrst) begin
      state          <= IDLE;
      addr_lo        <= '0;
      len_lo         <= '0;
      waddr          <= '0;
      words_left     <= '0;
      byte_idx       <= '0;
      word_sr        <= '0;
      tmr            <= '0;
      done_pend      <= 1'b0;
`ifdef CON_LOADER_CHKSUM_EN
      chk_acc        <= '0;
`endif
      bus.con_write  <= 4'h0;
      bus.con_addr   <= '0;
      bus.con_in     <= '0;
      bus.core_nrst  <= 1'b0;
      bus.load_busy  <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_err   <= 1'b0;
    end else begin
      bus.con_write <= 4'h0;

      // idle-gap timer restarts on every byte and is held loaded while no frame is open
      if (state == IDLE || bus.rx_valid)
        tmr <= TMR_W'(TIMEOUT_CYC - 1);
      else if (tmr != '0)
        tmr <= tmr - TMR_W'(1);

      // final word is in its write cycle; status flips after it
      if (done_pend) begin
        done_pend     <= 1'b0;
        bus.load_busy <= 1'b0;
        bus.load_done <= 1'b1;
        bus.core_nrst <= 1'b1;
      end

      if (state == IDLE) begin
        bus.core_nrst <= 1'b1;
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state         <= ADDR0;
          done_pend     <= 1'b0;
          byte_idx      <= '0;
          bus.load_busy <= 1'b1;
          bus.load_done <= 1'b0;
          bus.load_err  <= 1'b0;
          bus.core_nrst <= 1'b0;
`ifdef CON_LOADER_CHKSUM_EN
          chk_acc       <= '0;
`endif
        end
      end else if (bus.rx_valid) begin
        case (state)
          ADDR0: begin
            addr_lo <= bus.rx_data;
            state   <= ADDR1;
          end
          ADDR1: begin
            waddr <= ADDR_W'({bus.rx_data, addr_lo});
            state <= LEN0;
          end
          LEN0: begin
            len_lo <= bus.rx_data;
            state  <= LEN1;
          end
          LEN1: begin
            words_left <= {bus.rx_data, len_lo};
            byte_idx   <= '0;
            if ({bus.rx_data, len_lo} == 16'd0) begin
`ifdef CON_LOADER_CHKSUM_EN
              state         <= CHK;
`else
              state         <= IDLE;
              bus.load_busy <= 1'b0;
              bus.load_done <= 1'b1;
              bus.core_nrst <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
`ifdef CON_LOADER_CHKSUM_EN
            chk_acc  <= chk_acc ^ bus.rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.con_write <= 4'hF;
              bus.con_addr  <= waddr;
              bus.con_in    <= {bus.rx_data, word_sr};
              waddr         <= waddr + ADDR_W'(1);
              words_left    <= words_left - 16'd1;
              if (words_left == 16'd1) begin
`ifdef CON_LOADER_CHKSUM_EN
                state     <= CHK;
`else
                state     <= IDLE;
                done_pend <= 1'b1;
`endif
              end
            end else begin
              word_sr <= {bus.rx_data, word_sr[23:8]};
            end
          end
          CHK: begin
`ifdef CON_LOADER_CHKSUM_EN
            state         <= IDLE;
            bus.load_busy <= 1'b0;
            bus.core_nrst <= 1'b1;
            if (bus.rx_data == chk_acc)
              bus.load_done <= 1'b1;
            else
              bus.load_err  <= 1'b1;
`else
            state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end else if (tmr == '0) begin
        // abort: partial word dropped, words already written are left in memory
        state         <= IDLE;
        byte_idx      <= '0;
        bus.load_err  <= 1'b1;
        bus.load_busy <= 1'b0;
        bus.core_nrst <= 1'b1;
      end
    end
  end
endmodule
